// File: rtl/multicycle_ctrl.sv
// Multi-cycle MIPS main control FSM: fetch/decode/execute/memory/write-back sequencing,
// retired-instruction counter and sticky illegal-opcode flag. Optional macro: CTRL_MEM_WAIT_EN.
module multicycle_ctrl #(
    parameter int CNT_W = 32
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic [5:0]       opcode_i,
    input  logic             mem_ready_i,
    output logic             pc_write_o,
    output logic             pc_write_cond_o,
    output logic             i_or_d_o,
    output logic             mem_read_o,
    output logic             mem_write_o,
    output logic             ir_write_o,
    output logic             mem_to_reg_o,
    output logic             reg_dst_o,
    output logic             reg_write_o,
    output logic             alu_src_a_o,
    output logic [1:0]       alu_src_b_o,
    output logic [2:0]       alu_op_o,
    output logic [1:0]       pc_source_o,
    output logic [3:0]       state_o,
    output logic             instr_done_o,
    output logic             illegal_o,
    output logic [CNT_W-1:0] instr_cnt_o
);

    typedef enum logic [3:0] {
        S_FETCH     = 4'd0,
        S_DECODE    = 4'd1,
        S_MEM_ADDR  = 4'd2,
        S_MEM_READ  = 4'd3,
        S_MEM_WB    = 4'd4,
        S_MEM_WRITE = 4'd5,
        S_R_EXEC    = 4'd6,
        S_R_WB      = 4'd7,
        S_BRANCH    = 4'd8,
        S_JUMP      = 4'd9,
        S_I_EXEC    = 4'd10,
        S_I_WB      = 4'd11,
        S_IDLE      = 4'd15
    } state_t;

    localparam logic [5:0] OP_R    = 6'b000000;
    localparam logic [5:0] OP_ADDI = 6'b001000;
    localparam logic [5:0] OP_SLTI = 6'b001010;
    localparam logic [5:0] OP_BEQ  = 6'b000100;
    localparam logic [5:0] OP_LW   = 6'b100011;
    localparam logic [5:0] OP_SW   = 6'b101011;
    localparam logic [5:0] OP_J    = 6'b000010;

    state_t           state_q, state_d;
    logic             done_q, retire_d;
    logic             illegal_q, illegal_set_d;
    logic [CNT_W-1:0] cnt_q;
    logic             mem_done;

`ifdef CTRL_MEM_WAIT_EN
    assign mem_done = mem_ready_i;
`else
    logic unused_mem_ready;
    assign unused_mem_ready = mem_ready_i;
    assign mem_done         = 1'b1;
`endif

    always_comb begin
        state_d         = state_q;
        retire_d        = 1'b0;
        illegal_set_d   = 1'b0;
        pc_write_o      = 1'b0;
        pc_write_cond_o = 1'b0;
        i_or_d_o        = 1'b0;
        mem_read_o      = 1'b0;
        mem_write_o     = 1'b0;
        ir_write_o      = 1'b0;
        mem_to_reg_o    = 1'b0;
        reg_dst_o       = 1'b0;
        reg_write_o     = 1'b0;
        alu_src_a_o     = 1'b0;
        alu_src_b_o     = 2'b00;
        alu_op_o        = 3'd0;
        pc_source_o     = 2'b00;
        case (state_q)
            S_IDLE: state_d = S_FETCH;
            S_FETCH: begin
                mem_read_o  = 1'b1;
                alu_src_b_o = 2'b01;
                ir_write_o  = mem_done;
                pc_write_o  = mem_done;
                if (mem_done) state_d = S_DECODE;
            end
            S_DECODE: begin
                alu_src_b_o = 2'b11;
                case (opcode_i)
                    OP_LW, OP_SW:     state_d = S_MEM_ADDR;
                    OP_R:             state_d = S_R_EXEC;
                    OP_BEQ:           state_d = S_BRANCH;
                    OP_J:             state_d = S_JUMP;
                    OP_ADDI, OP_SLTI: state_d = S_I_EXEC;
                    default: begin
                        state_d       = S_FETCH;
                        illegal_set_d = 1'b1;
                    end
                endcase
            end
            S_MEM_ADDR: begin
                alu_src_a_o = 1'b1;
                alu_src_b_o = 2'b10;
                state_d     = (opcode_i == OP_LW) ? S_MEM_READ : S_MEM_WRITE;
            end
            S_MEM_READ: begin
                mem_read_o = 1'b1;
                i_or_d_o   = 1'b1;
                if (mem_done) state_d = S_MEM_WB;
            end
            S_MEM_WB: begin
                reg_write_o  = 1'b1;
                mem_to_reg_o = 1'b1;
                state_d      = S_FETCH;
                retire_d     = 1'b1;
            end
            S_MEM_WRITE: begin
                mem_write_o = 1'b1;
                i_or_d_o    = 1'b1;
                if (mem_done) begin
                    state_d  = S_FETCH;
                    retire_d = 1'b1;
                end
            end
            S_R_EXEC: begin
                alu_src_a_o = 1'b1;
                alu_op_o    = 3'd2;
                state_d     = S_R_WB;
            end
            S_R_WB: begin
                reg_dst_o   = 1'b1;
                reg_write_o = 1'b1;
                state_d     = S_FETCH;
                retire_d    = 1'b1;
            end
            S_BRANCH: begin
                alu_src_a_o     = 1'b1;
                alu_op_o        = 3'd1;
                pc_write_cond_o = 1'b1;
                pc_source_o     = 2'b01;
                state_d         = S_FETCH;
                retire_d        = 1'b1;
            end
            S_JUMP: begin
                pc_write_o  = 1'b1;
                pc_source_o = 2'b10;
                state_d     = S_FETCH;
                retire_d    = 1'b1;
            end
            S_I_EXEC: begin
                alu_src_a_o = 1'b1;
                alu_src_b_o = 2'b10;
                alu_op_o    = (opcode_i == OP_SLTI) ? 3'd3 : 3'd0;
                state_d     = S_I_WB;
            end
            S_I_WB: begin
                reg_write_o = 1'b1;
                state_d     = S_FETCH;
                retire_d    = 1'b1;
            end
            default: state_d = S_IDLE;
        endcase
    end

    // Retirement is registered so the pulse and count update land in the following FETCH.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q   <= S_IDLE;
            done_q    <= 1'b0;
            illegal_q <= 1'b0;
            cnt_q     <= '0;
        end else begin
            state_q <= state_d;
            done_q  <= retire_d;
            if (retire_d) cnt_q <= cnt_q + {{(CNT_W-1){1'b0}}, 1'b1};
            if (illegal_set_d) illegal_q <= 1'b1;
        end
    end

    assign state_o      = state_q;
    assign instr_done_o = done_q;
    assign illegal_o    = illegal_q;
    assign instr_cnt_o  = cnt_q;

endmodule

// File: doc/multicycle_ctrl.md
# multicycle_ctrl

Main control FSM for the multi-cycle MIPS datapath. It sequences instruction fetch, decode, execute, memory and write-back over several cycles, driving the register, memory and PC enables, the ALU operand muxes and the 3-bit ALUOp consumed by ALU_Ctrl. It also counts retired instructions and flags illegal opcodes.

## Interface
Parameters:
- CNT_W, 32, width of retired-instruction counter

Ports:
- clk_i  in  1  clock, rising edge
- rst_i  in  1  reset, asynchronous, active-high
- opcode_i  in  6  instruction[31:26] from IR; stable from DECODE onward
- mem_ready_i  in  1  memory access completes this cycle (used only with CTRL_MEM_WAIT_EN)
- pc_write_o  out  1  unconditional PC load
- pc_write_cond_o  out  1  PC load if ALU zero
- i_or_d_o  out  1  memory address: 0=PC, 1=ALUOut
- mem_read_o  out  1  memory read
- mem_write_o  out  1  memory write
- ir_write_o  out  1  IR load
- mem_to_reg_o  out  1  write-back data: 0=ALUOut, 1=MDR
- reg_dst_o  out  1  destination: 0=rt, 1=rd
- reg_write_o  out  1  register file write
- alu_src_a_o  out  1  0=PC, 1=A
- alu_src_b_o  out  2  00=B, 01=4, 10=sign-ext imm, 11=sign-ext imm<<2
- alu_op_o  out  3  0=add, 1=sub, 2=funct-decoded, 3=slt
- pc_source_o  out  2  00=ALU result, 01=ALUOut, 10=jump target
- state_o  out  4  current state, for debug
- instr_done_o  out  1  one-cycle pulse on instruction retirement
- illegal_o  out  1  sticky illegal-opcode flag
- instr_cnt_o  out  CNT_W  retired-instruction count

## Operation
- Opcodes: R=000000, addi=001000, slti=001010, beq=000100, lw=100011, sw=101011, j=000010. All others are illegal.
- States (encoding): IDLE=15, FETCH=0, DECODE=1, MEM_ADDR=2, MEM_READ=3, MEM_WB=4, MEM_WRITE=5, R_EXEC=6, R_WB=7, BRANCH=8, JUMP=9, I_EXEC=10, I_WB=11.
- Control outputs are decoded from state. Any output not listed for a state is 0.
- IDLE: all outputs 0. Next state is FETCH.
- FETCH: mem_read=1, alu_src_b=01, alu_op=0, pc_source=00. ir_write and pc_write are 1 only in the completing cycle. Next state is DECODE on completion.
- DECODE: alu_src_b=11, alu_op=0. Next state by opcode:
  - lw/sw → MEM_ADDR
  - R → R_EXEC
  - beq → BRANCH
  - j → JUMP
  - addi/slti → I_EXEC
  - illegal → FETCH, and illegal_o is set
- MEM_ADDR: alu_src_a=1, alu_src_b=10, alu_op=0. Next state is MEM_READ for lw, MEM_WRITE for sw.
- MEM_READ: mem_read=1, i_or_d=1. Next state is MEM_WB on completion.
- MEM_WB: reg_write=1, mem_to_reg=1. Next state is FETCH; the instruction retires.
- MEM_WRITE: mem_write=1, i_or_d=1. Next state is FETCH on completion; the instruction retires.
- R_EXEC: alu_src_a=1, alu_src_b=00, alu_op=2. Next state is R_WB.
- R_WB: reg_dst=1, reg_write=1. Next state is FETCH; retires.
- BRANCH: alu_src_a=1, alu_src_b=00, alu_op=1, pc_write_cond=1, pc_source=01. Next state is FETCH; retires.
- JUMP: pc_write=1, pc_source=10. Next state is FETCH; retires.
- I_EXEC: alu_src_a=1, alu_src_b=10. alu_op=0 for addi, 3 for slti. Next state is I_WB.
- I_WB: reg_write=1, reg_dst=0. Next state is FETCH; retires.
- Retirement: instr_done_o is a registered pulse in the first FETCH cycle after a retiring state. instr_cnt_o increments by 1 at the same edge and wraps modulo 2^CNT_W. An illegal opcode does not retire.

## Timing
- Reset values: state=IDLE, instr_cnt_o=0, illegal_o=0, instr_done_o=0. All control outputs are 0.
- Reset asserted mid-instruction returns to IDLE immediately. No write enables are asserted while reset is held.
- Latency with no wait states:
  - j, beq: 3 cycles
  - R, addi, slti, sw: 4 cycles
  - lw: 5 cycles
- Each cycle spent waiting in a memory state adds one cycle.
- Control outputs are combinational from state (ir_write/pc_write in FETCH also depend on mem_ready_i). instr_done_o, illegal_o and instr_cnt_o are registered.

## Configuration
- CTRL_MEM_WAIT_EN defined: FETCH, MEM_READ and MEM_WRITE are held until mem_ready_i=1. Read/write enables stay asserted while waiting. ir_write/pc_write pulse only in the cycle where mem_ready_i=1.
- CTRL_MEM_WAIT_EN undefined: mem_ready_i is ignored and every memory state completes in one cycle.

## Test plan
- Reset release, sw opcode 101011, no waits → state sequence 15,0,1,2,5,0. mem_write_o=1 for exactly one cycle. instr_cnt_o=1.
- lw 100011 with CTRL_MEM_WAIT_EN, mem_ready_i low for 2 cycles in MEM_READ → 7-cycle instruction. mem_read_o and i_or_d_o held high for 3 cycles. reg_write_o=1 and mem_to_reg_o=1 in MEM_WB.
- R-type then slti → alu_op_o=2 in R_EXEC with reg_dst_o=1 in R_WB. Then alu_op_o=3 in I_EXEC with reg_dst_o=0 in I_WB. instr_cnt_o=2.
- beq 000100 → BRANCH asserts alu_op_o=1, pc_write_cond_o=1, pc_source_o=01. Next state is FETCH. j asserts pc_write_o=1 with pc_source_o=10.
- Illegal opcode 111111 → DECODE→FETCH, illegal_o=1 and stays set. instr_cnt_o unchanged. instr_done_o not pulsed.
- rst_i raised during MEM_WRITE → state_o=15 and mem_write_o=0 asynchronously. instr_cnt_o=0, illegal_o=0.
